// File: rtl/alu_pkg.sv
// Shared ALU opcodes and sequencer state encoding.
// Imported by the sequencer, its interface users and the bench.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_B  = 3'd2,
        S_CAP_B = 3'd3,
        S_EXEC  = 3'd4,
        S_WB    = 3'd5
    } seq_state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of command, memory, ALU and response signals of alu_sequencer.
// slave: sequencer side; master: environment (command source, memory, ALU).
interface alu_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int MEM_W  = 16
);
    // command handshake
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_opcode;
    logic [ADDR_W-1:0] cmd_src_a;
    logic [ADDR_W-1:0] cmd_src_b;
    logic [ADDR_W-1:0] cmd_dst;
    // result memory port
    logic [ADDR_W-1:0] mem_addr;
    logic [MEM_W-1:0]  mem_data_in;
    logic              mem_write_en;
    logic [MEM_W-1:0]  mem_data_out;
    // ALU port
    logic [2:0]        alu_opcode;
    logic [DATA_W-1:0] alu_operand1;
    logic [DATA_W-1:0] alu_operand2;
    logic [DATA_W-1:0] alu_result;
    // completion
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_src_a, cmd_src_b, cmd_dst,
        output cmd_ready,
        output mem_addr, mem_data_in, mem_write_en,
        input  mem_data_out,
        output alu_opcode, alu_operand1, alu_operand2,
        input  alu_result,
        output rsp_valid, rsp_result, rsp_zero
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_src_a, cmd_src_b, cmd_dst,
        input  cmd_ready,
        input  mem_addr, mem_data_in, mem_write_en,
        output mem_data_out,
        input  alu_opcode, alu_operand1, alu_operand2,
        output alu_result,
        input  rsp_valid, rsp_result, rsp_zero
    );

endinterface

// File: rtl/alu_sequencer.sv
// Fixed-latency read/operate/write-back sequencer between result memory and ALU.
// Ports: clk, rst (sync, active high), bus (alu_sequencer_if.slave).
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int MEM_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    alu_sequencer_if.slave bus
);

    seq_state_e state_q, state_d;

    logic [2:0]        opc_q;
    logic [ADDR_W-1:0] src_a_q;
    logic [ADDR_W-1:0] src_b_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] res_q;
    logic [2:0]        alu_opc_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_result_q;
    logic              rsp_zero_q;

    assign bus.cmd_ready    = (state_q == S_IDLE) && !rst;
    assign bus.alu_opcode   = alu_opc_q;
    assign bus.alu_operand1 = alu_a_q;
    assign bus.alu_operand2 = alu_b_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_zero     = rsp_zero_q;

    always_comb begin
        state_d          = state_q;
        bus.mem_addr     = '0;
        bus.mem_data_in  = '0;
        bus.mem_write_en = 1'b0;
        unique case (state_q)
            S_IDLE:  if (bus.cmd_valid) state_d = S_RD_A;
            S_RD_A: begin
                bus.mem_addr = src_a_q;
                state_d      = S_RD_B;
            end
            S_RD_B: begin
                bus.mem_addr = src_b_q;
                state_d      = S_CAP_B;
            end
            S_CAP_B: state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB: begin
                // write is not gated by rst: a reset landing in WB still commits
                bus.mem_addr     = dst_q;
                bus.mem_write_en = 1'b1;
                bus.mem_data_in  = {{(MEM_W-DATA_W){1'b0}}, res_q};
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            opc_q        <= '0;
            src_a_q      <= '0;
            src_b_q      <= '0;
            dst_q        <= '0;
            op_a_q       <= '0;
            res_q        <= '0;
            alu_opc_q    <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        opc_q   <= bus.cmd_opcode;
                        src_a_q <= bus.cmd_src_a;
                        src_b_q <= bus.cmd_src_b;
                        dst_q   <= bus.cmd_dst;
                    end
                end
                S_RD_B: op_a_q <= bus.mem_data_out[DATA_W-1:0];
                S_CAP_B: begin
                    // ALU inputs load here so they are stable for all of
                    // EXEC and keep their value afterwards
                    alu_opc_q <= opc_q;
                    alu_a_q   <= op_a_q;
                    alu_b_q   <= bus.mem_data_out[DATA_W-1:0];
                end
                S_EXEC: res_q <= bus.alu_result;
                S_WB: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_result_q <= res_q;
                    rsp_zero_q   <= (res_q == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Control stage between `result_memory` and `alu`. It accepts one operation command per handshake, reads both operands from the 16-entry result memory, drives the combinational ALU, and writes the zero-extended result back to a destination address. It then reports completion with a one-cycle response pulse. It replaces the hand-sequenced read/operate/store flow with a fixed-latency FSM.

## Interface
Parameters:
- `DATA_W`, 8: ALU operand/result width.
- `ADDR_W`, 4: memory address width (16 entries).
- `MEM_W`, 16: memory word width; operands use bits `[DATA_W-1:0]`.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept; high only in IDLE and not in reset.
- `cmd_opcode`  in  3  ALU opcode.
- `cmd_src_a`  in  ADDR_W  operand1 address.
- `cmd_src_b`  in  ADDR_W  operand2 address.
- `cmd_dst`  in  ADDR_W  result address.
- `mem_addr`  out  ADDR_W  to `result_memory.addr`.
- `mem_data_in`  out  MEM_W  to `result_memory.data_in`.
- `mem_write_en`  out  1  to `result_memory.write_en`.
- `mem_data_out`  in  MEM_W  from `result_memory.data_out`, registered read with 1-cycle latency.
- `alu_opcode`  out  3  to `alu.opcode`.
- `alu_operand1`, `alu_operand2`  out  DATA_W  to ALU.
- `alu_result`  in  DATA_W  from ALU, combinational.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_result`  out  DATA_W  last written result, held until next completion.
- `rsp_zero`  out  1  `rsp_result == 0`, held with `rsp_result`.

## Operation
- The command is accepted on a rising edge with `cmd_valid && cmd_ready`. The sequencer latches opcode, src_a, src_b and dst.
- FSM states and per-cycle actions:
  - IDLE: `cmd_ready` is high. On accept, go to RD_A.
  - RD_A: `mem_addr=src_a`. Go to RD_B.
  - RD_B: `mem_addr=src_b`. Capture `op_a <= mem_data_out[DATA_W-1:0]`. Go to CAP_B.
  - CAP_B: capture `op_b <= mem_data_out[DATA_W-1:0]`. Go to EXEC.
  - EXEC: `alu_opcode/operand1/operand2` = latched opcode, `op_a`, `op_b`. Capture `result_r <= alu_result`. Go to WB.
  - WB: `mem_addr=dst`, `mem_write_en=1`, `mem_data_in={(MEM_W-DATA_W)'b0, result_r}`. Go to IDLE. Set `rsp_valid`, `rsp_result` and `rsp_zero` for the next cycle.
- `mem_write_en` is high only in WB. In all other states `mem_data_in` is 0.
- The ALU outputs hold their last driven values outside EXEC.
- Both operands are always read, even for NOT and the shifts, so latency is fixed.
- Arithmetic wraps modulo 2^DATA_W; no carry or borrow is reported. The upper memory bits of operands are ignored.
- Cases `src_a==src_b`, `dst==src_a` and `dst==src_b` are all legal. Operands are read before the write.
- While busy, `cmd_valid` is ignored and the command inputs need not be held.

## Timing
- Accept edge ends cycle 0. RD_A through WB occupy cycles 1–5.
- The memory write commits on the edge ending cycle 5.
- `rsp_valid` is high in cycle 6, which is also IDLE. A new command may be accepted in cycle 6, giving a throughput of 1 command per 6 cycles.
- Back-to-back dependency: the next command's RD_A is at cycle 7 at the earliest, after the write has committed, so no hazard exists.
- Reset values: state IDLE, `cmd_ready=0` while `rst` is high, and every other output 0.
- Reset in any state aborts the command. From the cycle after the reset edge, `mem_write_en=0`, so there is no partial write.
- Reset asserted during WB: the write in that cycle already occurs; `rsp_valid` does not pulse.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams `OP_ADD=3'b000`, `OP_SUB`, `OP_NOT`, `OP_AND`, `OP_OR`, `OP_XOR`, `OP_SHL`, `OP_SHR=3'b111`;
  - the sequencer state encoding, 3-bit, IDLE=0.
- No sub-module: a single FSM plus datapath registers. `alu` and `result_memory` are instantiated beside it at the next level up.

## Test plan
Preload mem[0]=0x0010, mem[1]=0x0020, mem[2]=0x0030 before each scenario.
- ADD src 0,1 dst 3 → write in cycle 5; then mem[3]=0x0030, `rsp_valid` in cycle 6, `rsp_result`=0x30, `rsp_zero`=0.
- Back-to-back: the command above, then SUB src 3,2 dst 4 accepted in cycle 6 → mem[4]=0x0000, `rsp_zero`=1.
- SUB src 0,1 dst 5 → 0xF0 (wrap). Also load mem[6]=0xAB12, then AND src 6,6 dst 7 → mem[7]=0x0012.
- `cmd_valid` held high with changing fields during cycles 1–5 → `cmd_ready`=0; only the first command executes, with exactly one write.
- `rst` pulsed during EXEC of ADD dst 3 → no write, mem[3] unchanged, `rsp_valid` never pulses; `cmd_ready`=1 the cycle after reset drops.
